// File: rtl/bus_ram_responder.sv
// bus_ram_responder: word-organised RAM slave with byte/halfword lanes, wait states and
// access checking. Define BUS_RSP_ERRCNT_EN to add the saturating err_count port.
module bus_ram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  len,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        exception
`ifdef BUS_RSP_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);
  // state | meaning
  // IDLE  | waiting for req; access latched and classified when req seen
  // WAIT  | legal access counting down its wait states
  // RESP  | one-cycle ack (exception if rejected); writes commit here
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           rw_q, illegal_q;
  logic [1:0]     len_q, lo_q;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wdata_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic [32:0]    offset;
  logic           in_range, misaligned, illegal_in;
  logic [AW-1:0]  cur_idx;
  logic [1:0]     cur_len, cur_lo;
  logic           cur_rw, cur_illegal;
  logic [31:0]    rd_word, rd_lane, wr_data;
  logic [3:0]     be;

  // 33-bit offset keeps the range test free of wrap-around near the top of the map
  always_comb begin
    offset     = {1'b0, addr} - {1'b0, BASE_ADDR};
    in_range   = (addr >= BASE_ADDR) && (offset < SPAN);
    misaligned = ((len == 2'b01) && addr[0]) || ((len == 2'b10) && (addr[1:0] != 2'b00));
    illegal_in = !in_range || misaligned || (len == 2'b11);
  end

  always_comb begin
    if (state_q == IDLE) begin
      cur_idx     = offset[AW+1:2];
      cur_len     = len;
      cur_lo      = addr[1:0];
      cur_rw      = rw;
      cur_illegal = illegal_in;
    end else begin
      cur_idx     = idx_q;
      cur_len     = len_q;
      cur_lo      = lo_q;
      cur_rw      = rw_q;
      cur_illegal = illegal_q;
    end
  end

  always_comb begin
    rd_word = mem[cur_idx];
    rd_lane = 32'd0;
    case (cur_len)
      2'b00:   rd_lane = {24'd0, rd_word[8*cur_lo +: 8]};
      2'b01:   rd_lane = {16'd0, (cur_lo[1] ? rd_word[31:16] : rd_word[15:0])};
      2'b10:   rd_lane = rd_word;
      default: rd_lane = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        if (illegal_in || (WAIT_STATES == 0)) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else cnt_d = cnt_q - 4'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ack is masked by rst_n so a reset landing in RESP aborts without a completion pulse
  assign ack       = rst_n && (state_q == RESP);
  assign exception = ack && illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == IDLE) && req) begin
        rw_q      <= rw;
        len_q     <= len;
        lo_q      <= addr[1:0];
        idx_q     <= offset[AW+1:2];
        wdata_q   <= wdata;
        illegal_q <= illegal_in;
      end
      if ((state_d == RESP) && (state_q != RESP)) begin
        if (cur_illegal)  rdata <= 32'd0;
        else if (!cur_rw) rdata <= rd_lane;
      end
    end
  end

  always_comb begin
    be      = 4'b0000;
    wr_data = wdata_q;
    case (len_q)
      2'b00: begin
        be      = 4'b0001 << lo_q;
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = lo_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && (state_q == RESP) && rw_q && !illegal_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

`ifdef BUS_RSP_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_count <= 8'd0;
    else if ((state_q == RESP) && illegal_q && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule
